// File: rtl/freq_synth_disp_if.sv
// Control, status, waveform and display signals of freq_synth_disp.
// The controller side drives freq_hz/load; the generator drives everything else.
interface freq_synth_disp_if;
  logic [6:0] freq_hz;
  logic       load;
  logic       busy;
  logic       err;
  logic       freq_out;
  logic [6:0] active_hz;
  logic [6:0] seg;
  logic [1:0] enable;

  modport master (
    output freq_hz, load,
    input  busy, err, freq_out, active_hz, seg, enable
  );

  modport slave (
    input  freq_hz, load,
    output busy, err, freq_out, active_hz, seg, enable
  );
endinterface

// File: rtl/freq_synth_disp.sv
// Programmable square-wave generator: 32-cycle divider, glitch-free swap at period wrap, 2-digit 7-seg scan.
// A load is taken only while busy=0; loads seen while busy are dropped, and busy holds until the new period starts.
module freq_synth_disp #(
  parameter int CLK_HZ   = 27_000_000,
  parameter int CNT_W    = 25,
  parameter int MAX_HZ   = 99,
  parameter int RESET_HZ = 42,
  parameter int SCAN_DIV = 225_000
) (
  input  logic             clk,
  input  logic             rst_n,
  freq_synth_disp_if.slave bus
);
  localparam int         RST_DIV = (CLK_HZ + RESET_HZ / 2) / RESET_HZ;
  localparam int         SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] MAX_F   = 7'(MAX_HZ);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PEND} state_t;

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_f;
  logic [31:0]       r_num;
  logic [7:0]        r_rem;
  logic [4:0]        r_iter;
  logic [CNT_W-1:0]  r_cnt, r_div;
  logic              r_fout, r_err, r_dsel;
  logic [6:0]        r_active;
  logic [SCAN_W-1:0] r_scan;

  logic       w_load_ok, w_wrap, w_swap, w_qbit;
  logic [7:0] w_trial, w_rem_nxt;
  logic [6:0] w_tens, w_units;

  assign w_load_ok = bus.load && (bus.freq_hz != 7'd0) && (bus.freq_hz <= MAX_F);
  assign w_wrap    = (r_cnt == r_div - 1'b1);
  assign w_swap    = (r_state == S_PEND) && w_wrap;

  // Remainder stays below f (<=99), so its low 7 bits plus the next numerator bit fit in 8.
  assign w_trial   = {r_rem[6:0], r_num[31]};
  assign w_qbit    = (w_trial >= {1'b0, r_f});
  assign w_rem_nxt = w_qbit ? (w_trial - {1'b0, r_f}) : w_trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load_ok) w_state_nxt = S_DIV;
      S_DIV:   if (r_iter == 5'd31) w_state_nxt = S_PEND;
      S_PEND:  if (w_wrap) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f    <= 7'd0;
      r_num  <= 32'd0;
      r_rem  <= 8'd0;
      r_iter <= 5'd0;
      r_err  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_load_ok) begin
        r_f    <= bus.freq_hz;
        r_num  <= 32'(CLK_HZ) + 32'(bus.freq_hz >> 1);
        r_rem  <= 8'd0;
        r_iter <= 5'd0;
        r_err  <= 1'b0;
      end else if (bus.load) begin
        r_err  <= 1'b1;
      end
    end else if (r_state == S_DIV) begin
      // Quotient bits shift in from the bottom as numerator bits leave the top.
      r_num  <= {r_num[30:0], w_qbit};
      r_rem  <= w_rem_nxt;
      r_iter <= r_iter + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_div    <= CNT_W'(RST_DIV);
      r_fout   <= 1'b0;
      r_active <= 7'(RESET_HZ);
    end else begin
      r_fout <= (r_cnt < (r_div >> 1));
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_swap) begin
        r_div    <= r_num[CNT_W-1:0];
        r_active <= r_f;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_dsel <= 1'b0;
    end else if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan <= '0;
      r_dsel <= ~r_dsel;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  function automatic logic [6:0] seg_enc(input logic [6:0] d);
    case (d)
      7'd0:    seg_enc = 7'b1111110;
      7'd1:    seg_enc = 7'b0110000;
      7'd2:    seg_enc = 7'b1101101;
      7'd3:    seg_enc = 7'b1111001;
      7'd4:    seg_enc = 7'b0110011;
      7'd5:    seg_enc = 7'b1011011;
      7'd6:    seg_enc = 7'b1011111;
      7'd7:    seg_enc = 7'b1110000;
      7'd8:    seg_enc = 7'b1111111;
      7'd9:    seg_enc = 7'b1111011;
      default: seg_enc = 7'b0000000;
    endcase
  endfunction

  assign w_tens  = r_active / 7'd10;
  assign w_units = r_active % 7'd10;

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.err       = r_err;
  assign bus.freq_out  = r_fout;
  assign bus.active_hz = r_active;
  assign bus.enable    = r_dsel ? 2'b01 : 2'b10;
  assign bus.seg       = r_dsel ? seg_enc(w_units) : seg_enc(w_tens);
endmodule

// File: tb/tb_freq_synth_disp.sv
// Directed bench for freq_synth_disp at CLK_HZ=1000, CNT_W=12, SCAN_DIV=4, RESET_HZ=10.
module tb_freq_synth_disp;
  localparam int LIM = 2000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  freq_synth_disp_if bus();

  freq_synth_disp #(
    .CLK_HZ(1000), .CNT_W(12), .MAX_HZ(99), .RESET_HZ(10), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the first negedge sample where freq_out has just gone high.
  task automatic wait_rise();
    int n = 0;
    while (bus.freq_out !== 1'b0 && n < LIM) begin cyc(1); n++; end
    while (bus.freq_out !== 1'b1 && n < LIM) begin cyc(1); n++; end
    chk("rise_timeout", 32'(n < LIM), 32'd1);
  endtask

  task automatic meas(output int hi, output int lo);
    wait_rise();
    hi = 0;
    lo = 0;
    while (bus.freq_out === 1'b1 && hi < LIM) begin cyc(1); hi++; end
    while (bus.freq_out === 1'b0 && lo < LIM) begin cyc(1); lo++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < LIM) begin cyc(1); n++; end
    chk("idle_timeout", 32'(n < LIM), 32'd1);
  endtask

  task automatic load(input logic [6:0] f);
    bus.freq_hz = f;
    bus.load    = 1'b1;
    cyc(1);
    bus.load    = 1'b0;
  endtask

  initial begin
    int hi, lo, nb, bh, bl, n;
    rst_n       = 1'b0;
    bus.freq_hz = 7'd0;
    bus.load    = 1'b0;
    cyc(2);

    // 1: reset state and 100-cycle period
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_fout", bus.freq_out, 0);
    chk("rst_active", bus.active_hz, 10);
    chk("rst_enable", bus.enable, 2'b10);
    chk("rst_seg", bus.seg, 7'b0110000);
    rst_n = 1'b1;
    meas(hi, lo);
    chk("p10_hi", hi, 50);
    chk("p10_lo", lo, 50);
    chk("p10_busy", bus.busy, 0);

    // 2: load 40 one cycle into a high phase; old period must finish intact
    load(7'd40);
    nb = 0; bh = 0; bl = 0;
    while (bus.busy === 1'b1 && nb < LIM) begin
      nb++;
      if (bus.freq_out === 1'b1) bh++; else bl++;
      cyc(1);
    end
    chk("busy_cycles", nb, 98);
    chk("old_hi_rest", bh, 49);
    chk("old_lo_rest", bl, 49);
    chk("swap_active", bus.active_hz, 40);
    chk("swap_fout", bus.freq_out, 0);
    meas(hi, lo);
    chk("p40_hi", hi, 12);
    chk("p40_lo", lo, 13);

    // 3: rejected loads then a valid one
    bus.freq_hz = 7'd0;
    bus.load    = 1'b1;
    cyc(1);
    chk("rej0_err", bus.err, 1);
    chk("rej0_busy", bus.busy, 0);
    chk("rej0_active", bus.active_hz, 40);
    bus.freq_hz = 7'd100;
    cyc(1);
    bus.load    = 1'b0;
    chk("rej100_err", bus.err, 1);
    chk("rej100_busy", bus.busy, 0);
    meas(hi, lo);
    chk("rej_hi", hi, 12);
    chk("rej_lo", lo, 13);
    load(7'd3);
    chk("ok3_err", bus.err, 0);
    chk("ok3_busy", bus.busy, 1);
    wait_idle();
    chk("ok3_active", bus.active_hz, 3);
    meas(hi, lo);
    chk("p3_hi", hi, 166);
    chk("p3_lo", lo, 167);

    // 4: load while busy is ignored
    load(7'd40);
    bus.freq_hz = 7'd7;
    bus.load    = 1'b1;
    cyc(3);
    chk("ign_busy", bus.busy, 1);
    bus.load    = 1'b0;
    wait_idle();
    chk("ign_active", bus.active_hz, 40);
    chk("ign_err", bus.err, 0);
    meas(hi, lo);
    chk("ign_hi", hi, 12);
    chk("ign_lo", lo, 13);

    // 5: display scan of 42
    load(7'd42);
    wait_idle();
    chk("d42_active", bus.active_hz, 42);
    n = 0;
    while (bus.enable !== 2'b01 && n < LIM) begin cyc(1); n++; end
    while (bus.enable !== 2'b10 && n < LIM) begin cyc(1); n++; end
    chk("scan_timeout", 32'(n < LIM), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("tens_en", bus.enable, 2'b10);
      chk("tens_seg", bus.seg, 7'b0110011);
      cyc(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("units_en", bus.enable, 2'b01);
      chk("units_seg", bus.seg, 7'b1101101);
      cyc(1);
    end

    // 6: asynchronous reset during division
    load(7'd40);
    cyc(4);
    chk("div_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_fout", bus.freq_out, 0);
    chk("arst_active", bus.active_hz, 10);
    chk("arst_enable", bus.enable, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    meas(hi, lo);
    chk("post_hi", hi, 50);
    chk("post_lo", lo, 50);
    chk("post_busy", bus.busy, 0);
    chk("post_active", bus.active_hz, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
